// File: rtl/projectile_scheduler.sv
// projectile_scheduler: shared projectile slot pool with player/enemy spawn arbitration and movement.
// Optional macro PLAYER_RESERVE_EN keeps one slot free for the player by restricting enemy grants.
module projectile_scheduler #(
    parameter int unsigned NUM_SLOTS      = 4,
    parameter int unsigned NUM_ENEMY      = 4,
    parameter int unsigned COOLDOWN       = 100_000_000,
    parameter int unsigned Y_TOP          = 144,
    parameter int unsigned Y_BOTTOM       = 444,
    parameter int unsigned Y_SPAWN_PLAYER = 444
) (
    input  logic                    clock_new,
    input  logic                    rst,
    input  logic                    move_tick,
    input  logic                    player_fire,
    input  logic [9:0]              player_x,
    input  logic [NUM_ENEMY-1:0]    enemy_req,
    input  logic [10*NUM_ENEMY-1:0] enemy_x,
    input  logic [10*NUM_ENEMY-1:0] enemy_y,
    input  logic [NUM_SLOTS-1:0]    hit_clear,
    output logic [NUM_SLOTS-1:0]    slot_active,
    output logic [NUM_SLOTS-1:0]    slot_owner,
    output logic [10*NUM_SLOTS-1:0] slot_x,
    output logic [10*NUM_SLOTS-1:0] slot_y,
    output logic                    player_grant,
    output logic [NUM_ENEMY-1:0]    enemy_grant,
    output logic                    player_ready
);
    localparam int unsigned PW = (NUM_ENEMY > 1) ? $clog2(NUM_ENEMY) : 1;
    localparam int unsigned SW = $clog2(NUM_SLOTS);
    localparam int unsigned FW = $clog2(NUM_SLOTS + 1);
    localparam int unsigned CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(COOLDOWN - 1);
    localparam logic [PW:0]   NE_W    = (PW+1)'(NUM_ENEMY);
    localparam logic [9:0]    YT      = 10'(Y_TOP);
    localparam logic [9:0]    YB      = 10'(Y_BOTTOM);
    localparam logic [9:0]    YSP     = 10'(Y_SPAWN_PLAYER);

    logic [PW-1:0]        rr_ptr;
    logic [CW-1:0]        cd_cnt;

    logic                 player_active;
    logic                 any_free;
    logic [FW-1:0]        free_cnt;
    logic                 alloc_found;
    logic [SW-1:0]        alloc_idx;
    logic                 player_ok;
    logic                 enemy_ok;
    logic [NUM_ENEMY-1:0] req_rot;
    logic                 enemy_found;
    logic [PW-1:0]        rot_off;
    logic [PW:0]          idx_sum;
    logic [PW-1:0]        enemy_idx;
    logic [NUM_ENEMY-1:0] enemy_onehot;
    logic [9:0]           spawn_x;
    logic [9:0]           spawn_y;

    // Free-slot census and lowest-index allocation target
    always_comb begin
        free_cnt    = '0;
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            if (!slot_active[k]) begin
                free_cnt = free_cnt + FW'(1);
                if (!alloc_found) begin
                    alloc_found = 1'b1;
                    alloc_idx   = SW'(k);
                end
            end
        end
        any_free      = (free_cnt != '0);
        player_active = |(slot_active & slot_owner);
        player_ok     = player_fire && player_ready && !player_active && any_free;
    end

    // Round-robin: rotate requests so index 0 is the pointer, take the first hit, then un-rotate
    always_comb begin
        req_rot     = NUM_ENEMY'({enemy_req, enemy_req} >> rr_ptr);
        enemy_found = 1'b0;
        rot_off     = '0;
        for (int unsigned i = 0; i < NUM_ENEMY; i++) begin
            if (!enemy_found && req_rot[i]) begin
                enemy_found = 1'b1;
                rot_off     = PW'(i);
            end
        end
        idx_sum = {1'b0, rr_ptr} + {1'b0, rot_off};
        if (idx_sum >= NE_W) begin
            idx_sum = idx_sum - NE_W;
        end
        enemy_idx = idx_sum[PW-1:0];
`ifdef PLAYER_RESERVE_EN
        enemy_ok = enemy_found && !player_ok && (free_cnt >= FW'(2)) && !player_active;
`else
        enemy_ok = enemy_found && !player_ok && any_free;
`endif
    end

    always_comb begin
        spawn_x      = player_x;
        spawn_y      = YSP;
        enemy_onehot = '0;
        for (int unsigned i = 0; i < NUM_ENEMY; i++) begin
            if (enemy_idx == PW'(i)) begin
                enemy_onehot[i] = enemy_ok;
                if (!player_ok) begin
                    spawn_x = enemy_x[10*i +: 10];
                    spawn_y = enemy_y[10*i +: 10];
                end
            end
        end
    end

    always_ff @(posedge clock_new) begin
        if (rst) begin
            slot_active  <= '0;
            slot_owner   <= '0;
            slot_x       <= '0;
            slot_y       <= '0;
            player_grant <= 1'b0;
            enemy_grant  <= '0;
            cd_cnt       <= CNT_MAX;
            player_ready <= 1'b1;
            rr_ptr       <= '0;
        end else begin
            player_grant <= player_ok;
            enemy_grant  <= enemy_onehot;

            if (enemy_ok) begin
                rr_ptr <= (enemy_idx == PW'(NUM_ENEMY - 1)) ? '0 : enemy_idx + PW'(1);
            end

            if (player_ok) begin
                cd_cnt       <= '0;
                player_ready <= (CNT_MAX == '0);
            end else if (cd_cnt != CNT_MAX) begin
                cd_cnt       <= cd_cnt + CW'(1);
                player_ready <= ((cd_cnt + CW'(1)) == CNT_MAX);
            end

            // Allocation targets only inactive slots, so it never collides with clear or movement
            for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
                if ((player_ok || enemy_ok) && (alloc_idx == SW'(k))) begin
                    slot_active[k]     <= 1'b1;
                    slot_owner[k]      <= player_ok;
                    slot_x[10*k +: 10] <= spawn_x;
                    slot_y[10*k +: 10] <= spawn_y;
                end else if (slot_active[k]) begin
                    if (hit_clear[k] ||
                        (move_tick && slot_owner[k]  && (slot_y[10*k +: 10] == YT)) ||
                        (move_tick && !slot_owner[k] && (slot_y[10*k +: 10] == YB))) begin
                        slot_active[k]     <= 1'b0;
                        slot_owner[k]      <= 1'b0;
                        slot_x[10*k +: 10] <= '0;
                        slot_y[10*k +: 10] <= '0;
                    end else if (move_tick) begin
                        if (slot_owner[k]) begin
                            slot_y[10*k +: 10] <= slot_y[10*k +: 10] - 10'd1;
                        end else begin
                            slot_y[10*k +: 10] <= slot_y[10*k +: 10] + 10'd1;
                        end
                    end
                end
            end
        end
    end

endmodule
